// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StDrop  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/pc_register.sv
// Fetch program counter with load enable and synchronous reset.
module pc_register #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues one outstanding imem request at a time, buffers a returned instruction
// while decode is stalled and squashes the stale request that is in flight across a redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(NOP_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCSrcE,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic             FlushD,
  input  logic             StallD,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_ack,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PCD,
  output logic [WIDTH-1:0] PCPlus4D,
  output logic             ValidD,
  output logic             FetchBusy
);

  localparam logic [WIDTH-1:0] Four = WIDTH'(4);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pcf;
  logic             pc_en;
  logic [WIDTH-1:0] pc_next;

  logic             d_load, d_bubble;
  logic [WIDTH-1:0] load_instr, load_pc;
  logic             buf_load, drop_load;

  logic [WIDTH-1:0] buf_instr_q, buf_pc_q, drop_addr_q;
  logic [WIDTH-1:0] instr_q, pcd_q, pcp4_q;
  logic             valid_q;

  pc_register #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_next),
    .q   (pcf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    pc_next    = pcf + Four;
    d_load     = 1'b0;
    d_bubble   = 1'b0;
    load_instr = imem_rdata;
    load_pc    = pcf;
    buf_load   = 1'b0;
    drop_load  = 1'b0;

    if (PCSrcE) begin
      pc_en    = 1'b1;
      pc_next  = PCTargetE;
      d_bubble = 1'b1;
      case (state_q)
        StFetch: begin
          if (!imem_ack) begin
            state_d   = StDrop;
            drop_load = 1'b1;
          end
        end
        StHold:  state_d = StFetch;
        StDrop:  if (imem_ack) state_d = StFetch;
        default: state_d = StFetch;
      endcase
    end else if (FlushD) begin
      // A returned instruction is dropped and PCF stays put, so it is refetched.
      d_bubble = 1'b1;
      case (state_q)
        StFetch: state_d = StFetch;
        StHold:  state_d = StFetch;
        StDrop:  if (imem_ack) state_d = StFetch;
        default: state_d = StFetch;
      endcase
    end else begin
      case (state_q)
        StFetch: begin
          if (imem_ack) begin
            pc_en = 1'b1;
            if (StallD) begin
              buf_load = 1'b1;
              state_d  = StHold;
            end else begin
              d_load = 1'b1;
            end
          end else if (!StallD) begin
            d_bubble = 1'b1;
          end
        end
        StHold: begin
          if (!StallD) begin
            d_load     = 1'b1;
            load_instr = buf_instr_q;
            load_pc    = buf_pc_q;
            state_d    = StFetch;
          end
        end
        StDrop: begin
          if (imem_ack) state_d = StFetch;
          if (!StallD) d_bubble = 1'b1;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_comb begin
    imem_req  = !rst && (state_q != StHold);
    imem_addr = (state_q == StDrop) ? drop_addr_q : pcf;
    FetchBusy = (state_q == StDrop) || ((state_q == StFetch) && !imem_ack);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q     <= NOP_INSTR;
      pcd_q       <= '0;
      pcp4_q      <= '0;
      valid_q     <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      drop_addr_q <= '0;
    end else begin
      if (d_bubble) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end else if (d_load) begin
        instr_q <= load_instr;
        pcd_q   <= load_pc;
        pcp4_q  <= load_pc + Four;
        valid_q <= 1'b1;
      end
      if (buf_load) begin
        buf_instr_q <= imem_rdata;
        buf_pc_q    <= pcf;
      end
      if (drop_load) begin
        drop_addr_q <= pcf;
      end
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a memory that returns 0xA0+addr after a set latency.
module tb_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, PCSrcE, FlushD, StallD;
  logic [31:0] PCTargetE;
  logic        imem_req, imem_ack, ValidD, FetchBusy;
  logic [31:0] imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;

  int lat = 1;
  bit blk = 1'b0;
  int wait_cnt = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .FlushD     (FlushD),
    .StallD     (StallD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .FetchBusy  (FetchBusy)
  );

  // Memory model: ack once the request has waited lat-1 cycles, unless blocked.
  assign imem_rdata = 32'hA0 + imem_addr;
  assign imem_ack   = imem_req && !blk && (wait_cnt >= lat - 1);

  always @(posedge clk) begin
    if (rst || imem_ack) wait_cnt <= 0;
    else if (imem_req)   wait_cnt <= wait_cnt + 1;
  end

  typedef struct {
    bit          rst, pcsrc, flush, stall;
    logic [31:0] target;
    int          lat;
    bit          blk;
    logic [31:0] instr, pcd, pcp4;
    bit          valid, req;
    logic [31:0] addr;
    bit          busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit ps, input logic [31:0] tg, input bit fl,
                     input bit st, input int lt, input bit bk, input logic [31:0] ei,
                     input logic [31:0] ep, input logic [31:0] e4, input bit ev,
                     input bit erq, input logic [31:0] ea, input bit eb);
    vec_t v;
    v.rst = r; v.pcsrc = ps; v.target = tg; v.flush = fl; v.stall = st;
    v.lat = lt; v.blk = bk;
    v.instr = ei; v.pcd = ep; v.pcp4 = e4; v.valid = ev; v.req = erq; v.addr = ea;
    v.busy = eb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    else n_pass++;
  endtask

  // Apply inputs, clock once, and sample 1 time unit after the edge.
  task automatic cycle(input bit r, input bit ps, input logic [31:0] tg, input bit fl,
                       input bit st, input int lt, input bit bk);
    rst = r; PCSrcE = ps; PCTargetE = tg; FlushD = fl; StallD = st; lat = lt; blk = bk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; PCSrcE = 1'b0; PCTargetE = '0; FlushD = 1'b0; StallD = 1'b0;

    //  rst ps target   fl st lt bk  instr    pcd      pcp4     v rq addr     busy
    add(1, 0, 'h0,   0, 0, 1, 0, Nop,     'h0,   'h0,   0, 0, 'h0,   1); // reset
    add(0, 0, 'h0,   0, 0, 1, 0, 'hA0,  'h0,   'h4,   1, 1, 'h4,   0); // zero-wait stream
    add(0, 0, 'h0,   0, 0, 1, 0, 'hA4,  'h4,   'h8,   1, 1, 'h8,   0);
    add(0, 0, 'h0,   0, 0, 1, 0, 'hA8,  'h8,   'hC,   1, 1, 'hC,   0);
    add(0, 0, 'h0,   0, 0, 1, 0, 'hAC,  'hC,   'h10,  1, 1, 'h10,  0);
    add(0, 0, 'h0,   0, 1, 1, 0, 'hAC,  'hC,   'h10,  1, 0, 'h14,  0); // ack at 0x10 -> HOLD
    add(0, 0, 'h0,   0, 1, 1, 0, 'hAC,  'hC,   'h10,  1, 0, 'h14,  0);
    add(0, 0, 'h0,   0, 1, 1, 0, 'hAC,  'hC,   'h10,  1, 0, 'h14,  0);
    add(0, 0, 'h0,   0, 0, 1, 0, 'hB0,  'h10,  'h14,  1, 1, 'h14,  0); // release buffer
    add(0, 0, 'h0,   0, 0, 1, 0, 'hB4,  'h14,  'h18,  1, 1, 'h18,  0);
    add(0, 0, 'h0,   0, 0, 1, 0, 'hB8,  'h18,  'h1C,  1, 1, 'h1C,  0);
    add(0, 0, 'h0,   0, 0, 1, 0, 'hBC,  'h1C,  'h20,  1, 1, 'h20,  0);
    add(0, 0, 'h0,   0, 0, 1, 1, Nop,     'h1C,  'h20,  0, 1, 'h20,  1); // 0x20 outstanding
    add(0, 1, 'h100, 0, 0, 1, 1, Nop,     'h1C,  'h20,  0, 1, 'h20,  1); // redirect -> DROP
    add(0, 0, 'h0,   0, 0, 1, 1, Nop,     'h1C,  'h20,  0, 1, 'h20,  1);
    add(0, 0, 'h0,   0, 0, 1, 0, Nop,     'h1C,  'h20,  0, 1, 'h100, 0); // stale data dropped
    add(0, 0, 'h0,   0, 0, 1, 0, 'h1A0, 'h100, 'h104, 1, 1, 'h104, 0);
    add(0, 0, 'h0,   0, 1, 1, 0, 'h1A0, 'h100, 'h104, 1, 0, 'h108, 0); // HOLD
    add(0, 1, 'h200, 0, 1, 1, 0, Nop,     'h100, 'h104, 0, 1, 'h200, 0); // redirect in HOLD
    add(0, 0, 'h0,   0, 0, 1, 0, 'h2A0, 'h200, 'h204, 1, 1, 'h204, 0);
    add(0, 0, 'h0,   1, 0, 1, 0, Nop,     'h200, 'h204, 0, 1, 'h204, 0); // flush drops ack
    add(0, 0, 'h0,   0, 0, 1, 0, 'h2A4, 'h204, 'h208, 1, 1, 'h208, 0);
    add(0, 0, 'h0,   0, 0, 1, 1, Nop,     'h204, 'h208, 0, 1, 'h208, 1);
    add(0, 1, 'h300, 0, 0, 1, 1, Nop,     'h204, 'h208, 0, 1, 'h208, 1); // DROP
    add(1, 0, 'h0,   0, 0, 1, 1, Nop,     'h0,   'h0,   0, 0, 'h0,   1); // reset in DROP
    add(0, 0, 'h0,   0, 0, 1, 0, 'hA0,  'h0,   'h4,   1, 1, 'h4,   0);
    add(0, 0, 'h0,   0, 0, 2, 0, Nop,     'h0,   'h4,   0, 1, 'h4,   0); // 2-cycle latency
    add(0, 0, 'h0,   0, 0, 2, 0, 'hA4,  'h4,   'h8,   1, 1, 'h8,   1);
    add(0, 0, 'h0,   0, 0, 2, 0, Nop,     'h4,   'h8,   0, 1, 'h8,   0);
    add(0, 0, 'h0,   0, 0, 2, 0, 'hA8,  'h8,   'hC,   1, 1, 'hC,   1);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].pcsrc, vecs[i].target, vecs[i].flush, vecs[i].stall,
            vecs[i].lat, vecs[i].blk);
      chk("InstrD",    i, InstrD,    vecs[i].instr);
      chk("PCD",       i, PCD,       vecs[i].pcd);
      chk("PCPlus4D",  i, PCPlus4D,  vecs[i].pcp4);
      chk("ValidD",    i, 32'(ValidD),    32'(vecs[i].valid));
      chk("imem_req",  i, 32'(imem_req),  32'(vecs[i].req));
      chk("imem_addr", i, imem_addr, vecs[i].addr);
      chk("FetchBusy", i, 32'(FetchBusy), 32'(vecs[i].busy));
    end

    // FlushD outranks StallD in HOLD: buffered 0xAC is lost, fetch resumes at 0x10.
    cycle(0, 0, 'h0, 0, 1, 1, 0);
    chk("hold_req", 100, 32'(imem_req), 32'h0);
    chk("hold_instr", 100, InstrD, 32'hA8);
    cycle(0, 0, 'h0, 1, 1, 1, 0);
    chk("flush_hold_valid", 101, 32'(ValidD), 32'h0);
    chk("flush_hold_instr", 101, InstrD, Nop);
    chk("flush_hold_pcd", 101, PCD, 32'h8);
    chk("flush_hold_addr", 101, imem_addr, 32'h10);
    cycle(0, 0, 'h0, 0, 0, 1, 0);
    chk("resume_instr", 102, InstrD, 32'hB0);
    chk("resume_pcd", 102, PCD, 32'h10);

    // PCSrcE outranks FlushD with an ack in FETCH: data discarded, fetch at target.
    cycle(0, 1, 'h40, 1, 0, 1, 0);
    chk("redir_flush_valid", 103, 32'(ValidD), 32'h0);
    chk("redir_flush_addr", 103, imem_addr, 32'h40);
    cycle(0, 0, 'h0, 0, 0, 1, 0);
    chk("redir_flush_instr", 104, InstrD, 32'hE0);
    chk("redir_flush_pcd", 104, PCD, 32'h40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
